// File: rtl/mem_bus_pkg.sv
// Shared definitions for the memory/IO bus controller: IO map, FSM states,
// byte-enable encodings and sub-word extension helpers.
package mem_bus_pkg;

  localparam logic [31:0] UART_DATA_ADDR = 32'hBFD0_03F8;
  localparam logic [31:0] UART_STAT_ADDR = 32'hBFD0_03FC;
  localparam logic [31:0] LED_ADDR       = 32'hBFD0_0400;
  localparam logic [31:0] DPY_ADDR       = 32'hBFD0_0408;

  localparam logic [3:0] BE_B0   = 4'b0001;
  localparam logic [3:0] BE_B1   = 4'b0010;
  localparam logic [3:0] BE_B2   = 4'b0100;
  localparam logic [3:0] BE_B3   = 4'b1000;
  localparam logic [3:0] BE_HLO  = 4'b0011;
  localparam logic [3:0] BE_HHI  = 4'b1100;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef enum logic [3:0] {
    IDLE,
    SRAM_RD,
    SRAM_SETUP,
    SRAM_WR,
    SRAM_HOLD,
    UART_RD,
    UART_WR,
    UART_WAIT,
    ACK
  } state_t;

  typedef enum logic [2:0] {
    TGT_SRAM,
    TGT_UART_DATA,
    TGT_UART_STAT,
    TGT_LED,
    TGT_DPY
  } tgt_t;

  function automatic tgt_t decode_tgt(input logic [31:0] addr);
    tgt_t t;
    case (addr)
      UART_DATA_ADDR: t = TGT_UART_DATA;
      UART_STAT_ADDR: t = TGT_UART_STAT;
      LED_ADDR:       t = TGT_LED;
      DPY_ADDR:       t = TGT_DPY;
      default:        t = TGT_SRAM;
    endcase
    return t;
  endfunction

  function automatic logic [31:0] ext8(input logic [7:0] b, input logic zext);
    return zext ? {24'b0, b} : {{24{b[7]}}, b};
  endfunction

  function automatic logic [31:0] ext16(input logic [15:0] h, input logic zext);
    return zext ? {16'b0, h} : {{16{h[15]}}, h};
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: extracts/extends sub-word read data and places
// right-aligned write data on the byte lanes selected by be.
module mem_lane_align
  import mem_bus_pkg::*;
(
  input  logic [3:0]  be,
  input  logic        zext,
  input  logic [31:0] rd_word,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic [31:0] wr_word
);

  always_comb begin
    rd_data = rd_word;
    wr_word = wr_data;
    case (be)
      BE_B0: begin
        rd_data = ext8(rd_word[7:0], zext);
        wr_word = {24'b0, wr_data[7:0]};
      end
      BE_B1: begin
        rd_data = ext8(rd_word[15:8], zext);
        wr_word = {16'b0, wr_data[7:0], 8'b0};
      end
      BE_B2: begin
        rd_data = ext8(rd_word[23:16], zext);
        wr_word = {8'b0, wr_data[7:0], 16'b0};
      end
      BE_B3: begin
        rd_data = ext8(rd_word[31:24], zext);
        wr_word = {wr_data[7:0], 24'b0};
      end
      BE_HLO: begin
        rd_data = ext16(rd_word[15:0], zext);
        wr_word = {16'b0, wr_data[15:0]};
      end
      BE_HHI: begin
        rd_data = ext16(rd_word[31:16], zext);
        wr_word = {wr_data[15:0], 16'b0};
      end
      // Full word and malformed enables pass the raw word through.
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Request/acknowledge bus controller for SRAM banks, parallel-strobe UART and
// LED/DPY registers. Every strobe and drive enable is a registered Moore output.
module mem_bus_ctrl
  import mem_bus_pkg::*;
#(
  parameter int NUM_BANKS  = 2,
  parameter int SRAM_WAIT  = 1,
  parameter int UART_PULSE = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req,
  input  logic                   req_we,
  input  logic [31:0]            req_addr,
  input  logic [3:0]             req_be,
  input  logic                   req_unsigned,
  input  logic [31:0]            req_wdata,
  output logic                   ack,
  output logic [31:0]            rdata,
  inout  wire  [32*NUM_BANKS-1:0] sram_data,
  output logic [19:0]            sram_addr,
  output logic [3:0]             sram_be_n,
  output logic [NUM_BANKS-1:0]   sram_ce_n,
  output logic [NUM_BANKS-1:0]   sram_oe_n,
  output logic [NUM_BANKS-1:0]   sram_we_n,
  output logic                   uart_rdn,
  output logic                   uart_wrn,
  input  logic                   uart_dataready,
  input  logic                   uart_tbre,
  input  logic                   uart_tsre,
  output logic [15:0]            debug_leds,
  output logic [7:0]             debug_dpys
);

  localparam logic [1:0] BANK_MASK = 2'(NUM_BANKS - 1);
  localparam logic [2:0] SRAM_CNT0 = 3'(SRAM_WAIT - 1);
  localparam logic [2:0] UART_CNT0 = 3'(UART_PULSE - 1);
  localparam logic [NUM_BANKS-1:0] BANK0_OH = NUM_BANKS'(1);

  state_t state, state_nxt;
  tgt_t   tgt;
  logic [2:0] cnt, cnt_nxt;
  logic [1:0] bank;
  logic [NUM_BANKS-1:0] bank_oh;
  logic [31:0] raw_word, rd_aligned, wr_word;

  logic [NUM_BANKS-1:0] drv_en, drv_en_nxt;
  logic [31:0] dout, dout_nxt;
  logic        ack_nxt;
  logic [31:0] rdata_nxt;
  logic [19:0] addr_nxt;
  logic [3:0]  be_n_nxt;
  logic [NUM_BANKS-1:0] ce_n_nxt, oe_n_nxt, we_n_nxt;
  logic        rdn_nxt, wrn_nxt;
  logic [15:0] leds_nxt;
  logic [7:0]  dpys_nxt;
  logic        sram_wr_phase;

  assign tgt  = decode_tgt(req_addr);
  // Bank bits above the populated range are masked off, so every address lands in a real bank.
  assign bank = req_addr[23:22] & BANK_MASK;

  always_comb begin
    bank_oh  = '0;
    raw_word = '0;
    for (int k = 0; k < NUM_BANKS; k++) begin
      bank_oh[k] = (bank == 2'(k));
      if (bank == 2'(k)) raw_word = sram_data[32*k +: 32];
    end
  end

  mem_lane_align u_align (
    .be      (req_be),
    .zext    (req_unsigned),
    .rd_word (raw_word),
    .wr_data (req_wdata),
    .rd_data (rd_aligned),
    .wr_word (wr_word)
  );

  for (genvar k = 0; k < NUM_BANKS; k++) begin : g_bus
    assign sram_data[32*k +: 32] = drv_en[k] ? dout : 32'bz;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rdata_nxt = rdata;
    addr_nxt  = sram_addr;
    leds_nxt  = debug_leds;
    dpys_nxt  = debug_dpys;

    case (state)
      IDLE: begin
        if (req) begin
          addr_nxt = req_addr[21:2];
          case (tgt)
            TGT_SRAM: begin
              state_nxt = req_we ? SRAM_SETUP : SRAM_RD;
              cnt_nxt   = SRAM_CNT0;
            end
            TGT_UART_DATA: begin
              state_nxt = req_we ? UART_WR : UART_RD;
              cnt_nxt   = UART_CNT0;
            end
            TGT_UART_STAT: begin
              state_nxt = ACK;
              if (!req_we) rdata_nxt = {30'b0, uart_dataready, uart_tbre & uart_tsre};
            end
            TGT_LED: begin
              state_nxt = ACK;
              if (req_we) leds_nxt = req_wdata[15:0];
              else        rdata_nxt = {16'b0, debug_leds};
            end
            default: begin
              state_nxt = ACK;
              if (req_we) dpys_nxt = req_wdata[7:0];
              else        dpys_nxt = debug_dpys;
              if (!req_we) rdata_nxt = {24'b0, debug_dpys};
            end
          endcase
        end
      end
      SRAM_RD: begin
        if (cnt == 3'd0) begin
          state_nxt = ACK;
          rdata_nxt = rd_aligned;
        end else begin
          cnt_nxt = cnt - 3'd1;
        end
      end
      SRAM_SETUP: begin
        state_nxt = SRAM_WR;
        cnt_nxt   = SRAM_CNT0;
      end
      SRAM_WR: begin
        if (cnt == 3'd0) state_nxt = SRAM_HOLD;
        else             cnt_nxt   = cnt - 3'd1;
      end
      SRAM_HOLD: state_nxt = ACK;
      UART_RD: begin
        if (cnt == 3'd0) begin
          state_nxt = ACK;
          rdata_nxt = {24'b0, sram_data[7:0]};
        end else begin
          cnt_nxt = cnt - 3'd1;
        end
      end
      UART_WR: begin
        if (cnt == 3'd0) state_nxt = UART_WAIT;
        else             cnt_nxt   = cnt - 3'd1;
      end
      UART_WAIT: if (uart_tbre && uart_tsre) state_nxt = ACK;
      default: state_nxt = IDLE;
    endcase

    // Outputs follow the state being entered, so they change on the same edge.
    sram_wr_phase = (state_nxt == SRAM_SETUP) || (state_nxt == SRAM_WR) ||
                    (state_nxt == SRAM_HOLD);
    ack_nxt  = (state_nxt == ACK);
    ce_n_nxt = (sram_wr_phase || state_nxt == SRAM_RD) ? ~bank_oh : '1;
    oe_n_nxt = (state_nxt == SRAM_RD) ? ~bank_oh : '1;
    we_n_nxt = (state_nxt == SRAM_WR) ? ~bank_oh : '1;
    be_n_nxt = (state_nxt == SRAM_RD) ? 4'h0 : (sram_wr_phase ? ~req_be : 4'hF);
    rdn_nxt  = (state_nxt != UART_RD);
    wrn_nxt  = (state_nxt != UART_WR);

    drv_en_nxt = '0;
    dout_nxt   = '0;
    if (sram_wr_phase) begin
      drv_en_nxt = bank_oh;
      dout_nxt   = wr_word;
    end else if (state_nxt == UART_WR || state_nxt == UART_WAIT) begin
      drv_en_nxt = BANK0_OH;
      dout_nxt   = {24'b0, req_wdata[7:0]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      ack        <= 1'b0;
      rdata      <= '0;
      sram_addr  <= '0;
      sram_be_n  <= 4'hF;
      sram_ce_n  <= '1;
      sram_oe_n  <= '1;
      sram_we_n  <= '1;
      uart_rdn   <= 1'b1;
      uart_wrn   <= 1'b1;
      drv_en     <= '0;
      dout       <= '0;
      debug_leds <= '0;
      debug_dpys <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      ack        <= ack_nxt;
      rdata      <= rdata_nxt;
      sram_addr  <= addr_nxt;
      sram_be_n  <= be_n_nxt;
      sram_ce_n  <= ce_n_nxt;
      sram_oe_n  <= oe_n_nxt;
      sram_we_n  <= we_n_nxt;
      uart_rdn   <= rdn_nxt;
      uart_wrn   <= wrn_nxt;
      drv_en     <= drv_en_nxt;
      dout       <= dout_nxt;
      debug_leds <= leds_nxt;
      debug_dpys <= dpys_nxt;
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl with a two-bank SRAM model and a UART status model.
module tb_mem_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        req_we;
  logic [31:0] req_addr;
  logic [3:0]  req_be;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        ack;
  logic [31:0] rdata;
  wire  [63:0] sram_data;
  logic [19:0] sram_addr;
  logic [3:0]  sram_be_n;
  logic [1:0]  sram_ce_n, sram_oe_n, sram_we_n;
  logic        uart_rdn, uart_wrn;
  logic        uart_dataready;
  logic        uart_tbre = 1'b1;
  logic        uart_tsre = 1'b1;
  logic [15:0] debug_leds;
  logic [7:0]  debug_dpys;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [2][16];
  logic [31:0] uart_bus_val = 32'hFFFF_FF5A;
  logic        probe_en = 1'b0;
  logic [31:0] probe_val = 32'h1357_2468;
  int          hold = 0;

  logic [31:0] t_rdata, t_bus;
  int          t_cycles, t_oe_low, t_we_low, t_rdn_low, t_wrn_low;
  logic [1:0]  t_ce_seen;
  logic        t_ack_after;

  always #5 clk = ~clk;

  mem_bus_ctrl #(.NUM_BANKS(2), .SRAM_WAIT(1), .UART_PULSE(2)) dut (
    .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_be(req_be), .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .ack(ack), .rdata(rdata), .sram_data(sram_data), .sram_addr(sram_addr),
    .sram_be_n(sram_be_n), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .uart_rdn(uart_rdn), .uart_wrn(uart_wrn),
    .uart_dataready(uart_dataready), .uart_tbre(uart_tbre), .uart_tsre(uart_tsre),
    .debug_leds(debug_leds), .debug_dpys(debug_dpys)
  );

  for (genvar k = 0; k < 2; k++) begin : g_model
    logic        en;
    logic [31:0] val;
    always_comb begin
      en  = 1'b0;
      val = '0;
      if (!sram_ce_n[k] && !sram_oe_n[k]) begin
        en  = 1'b1;
        val = mem[k][sram_addr[3:0]];
      end else if (k == 0 && !uart_rdn) begin
        en  = 1'b1;
        val = uart_bus_val;
      end else if (k == 1 && probe_en) begin
        en  = 1'b1;
        val = probe_val;
      end
    end
    assign sram_data[32*k +: 32] = en ? val : 32'bz;
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++)
      for (int b = 0; b < 4; b++)
        if (!sram_ce_n[k] && !sram_we_n[k] && !sram_be_n[b])
          mem[k][sram_addr[3:0]][8*b +: 8] <= sram_data[32*k + 8*b +: 8];
  end

  // Transmitter stays busy for 10 cycles after the write strobe releases.
  always @(posedge clk) begin
    if (!uart_wrn) begin
      uart_tbre <= 1'b0;
      uart_tsre <= 1'b0;
      hold      <= 10;
    end else if (hold > 0) begin
      hold <= hold - 1;
      if (hold == 1) begin
        uart_tbre <= 1'b1;
        uart_tsre <= 1'b1;
      end
    end
  end

  task automatic txn(input logic we, input logic [31:0] addr, input logic [3:0] be,
                     input logic uns, input logic [31:0] wd, input bit b2b);
    bit done = 0;
    req = 1'b1; req_we = we; req_addr = addr; req_be = be;
    req_unsigned = uns; req_wdata = wd;
    t_cycles = 0; t_oe_low = 0; t_we_low = 0; t_rdn_low = 0; t_wrn_low = 0;
    t_ce_seen = 2'b00; t_bus = '0;
    while (!done && t_cycles < 100) begin
      @(posedge clk); #1;
      t_cycles++;
      if (!sram_oe_n[1] || !sram_oe_n[0]) t_oe_low++;
      if (!sram_we_n[1] || !sram_we_n[0]) t_we_low++;
      if (!uart_rdn) t_rdn_low++;
      if (!uart_wrn) begin t_wrn_low++; t_bus = sram_data[31:0]; end
      t_ce_seen = t_ce_seen | ~sram_ce_n;
      if (ack) done = 1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL txn_timeout addr=%h: no ack within %0d cycles", addr, t_cycles);
    end
    t_rdata = rdata;
    req = 1'b0;
    if (!b2b) begin
      @(posedge clk); #1;
    end
    t_ack_after = ack;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 1'b0; req_we = 1'b0; req_addr = '0; req_be = 4'hF;
    req_unsigned = 1'b0; req_wdata = '0; uart_dataready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rst_ack got=%b exp=0", ack); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got=%h exp=0", rdata); end
    checks++; if (sram_ce_n !== 2'b11) begin errors++; $display("FAIL rst_ce_n got=%b exp=11", sram_ce_n); end
    checks++; if (sram_oe_n !== 2'b11) begin errors++; $display("FAIL rst_oe_n got=%b exp=11", sram_oe_n); end
    checks++; if (sram_we_n !== 2'b11) begin errors++; $display("FAIL rst_we_n got=%b exp=11", sram_we_n); end
    checks++; if (sram_be_n !== 4'hF) begin errors++; $display("FAIL rst_be_n got=%h exp=f", sram_be_n); end
    checks++; if ({uart_rdn, uart_wrn} !== 2'b11) begin errors++; $display("FAIL rst_uart got=%b exp=11", {uart_rdn, uart_wrn}); end
    checks++; if (debug_leds !== 16'h0) begin errors++; $display("FAIL rst_leds got=%h exp=0", debug_leds); end
    checks++; if (debug_dpys !== 8'h0) begin errors++; $display("FAIL rst_dpys got=%h exp=0", debug_dpys); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_sram_word();
    txn(1'b1, 32'h8040_0010, 4'hF, 1'b0, 32'hDEAD_BEEF, 1'b0);
    checks++; if (t_cycles != 4) begin errors++; $display("FAIL sw_latency got=%0d exp=4", t_cycles); end
    checks++; if (t_we_low != 1) begin errors++; $display("FAIL sw_we_width got=%0d exp=1", t_we_low); end
    checks++; if (t_ce_seen !== 2'b10) begin errors++; $display("FAIL sw_ce_bank got=%b exp=10", t_ce_seen); end
    txn(1'b1, 32'h8000_0010, 4'hF, 1'b0, 32'h0BAD_F00D, 1'b0);
    txn(1'b0, 32'h8040_0010, 4'hF, 1'b0, 32'h0, 1'b0);
    checks++; if (t_cycles != 2) begin errors++; $display("FAIL sr_latency got=%0d exp=2", t_cycles); end
    checks++; if (t_oe_low != 1) begin errors++; $display("FAIL sr_oe_width got=%0d exp=1", t_oe_low); end
    checks++; if (t_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sr_data got=%h exp=deadbeef", t_rdata); end
    checks++; if (t_ack_after !== 1'b0) begin errors++; $display("FAIL sr_ack_pulse got=%b exp=0", t_ack_after); end
    txn(1'b0, 32'h8000_0010, 4'hF, 1'b0, 32'h0, 1'b0);
    checks++; if (t_rdata !== 32'h0BAD_F00D) begin errors++; $display("FAIL sr_bank0 got=%h exp=0badf00d", t_rdata); end
  endtask

  task automatic test_lanes();
    txn(1'b1, 32'h8040_0014, 4'hF, 1'b0, 32'h1122_3344, 1'b0);
    txn(1'b1, 32'h8040_0016, 4'b0100, 1'b0, 32'h0000_00A5, 1'b0);
    txn(1'b0, 32'h8040_0014, 4'hF, 1'b0, 32'h0, 1'b0);
    checks++; if (t_rdata !== 32'h11A5_3344) begin errors++; $display("FAIL sb_merge got=%h exp=11a53344", t_rdata); end
    txn(1'b0, 32'h8040_0016, 4'b0100, 1'b0, 32'h0, 1'b0);
    checks++; if (t_rdata !== 32'hFFFF_FFA5) begin errors++; $display("FAIL lb got=%h exp=ffffffa5", t_rdata); end
    txn(1'b0, 32'h8040_0016, 4'b0100, 1'b1, 32'h0, 1'b0);
    checks++; if (t_rdata !== 32'h0000_00A5) begin errors++; $display("FAIL lbu got=%h exp=000000a5", t_rdata); end
    txn(1'b1, 32'h8040_0018, 4'hF, 1'b0, 32'h8000_ABCD, 1'b0);
    txn(1'b0, 32'h8040_001A, 4'b1100, 1'b0, 32'h0, 1'b0);
    checks++; if (t_rdata !== 32'hFFFF_8000) begin errors++; $display("FAIL lh got=%h exp=ffff8000", t_rdata); end
    txn(1'b0, 32'h8040_0018, 4'b0011, 1'b1, 32'h0, 1'b0);
    checks++; if (t_rdata !== 32'h0000_ABCD) begin errors++; $display("FAIL lhu got=%h exp=0000abcd", t_rdata); end
  endtask

  task automatic test_uart_write();
    txn(1'b1, 32'hBFD0_03F8, 4'b0001, 1'b0, 32'hFFFF_FF41, 1'b0);
    checks++; if (t_wrn_low != 2) begin errors++; $display("FAIL uw_wrn_width got=%0d exp=2", t_wrn_low); end
    checks++; if (t_cycles != 14) begin errors++; $display("FAIL uw_latency got=%0d exp=14", t_cycles); end
    checks++; if (t_bus !== 32'h0000_0041) begin errors++; $display("FAIL uw_bus got=%h exp=00000041", t_bus); end
  endtask

  task automatic test_uart_read();
    uart_dataready = 1'b1;
    txn(1'b0, 32'hBFD0_03FC, 4'hF, 1'b0, 32'h0, 1'b0);
    checks++; if (t_rdata !== 32'h3) begin errors++; $display("FAIL ustat got=%h exp=3", t_rdata); end
    checks++; if (t_cycles != 1) begin errors++; $display("FAIL ustat_latency got=%0d exp=1", t_cycles); end
    txn(1'b0, 32'hBFD0_03F8, 4'hF, 1'b0, 32'h0, 1'b0);
    checks++; if (t_rdata !== 32'h0000_005A) begin errors++; $display("FAIL urd got=%h exp=5a", t_rdata); end
    checks++; if (t_rdn_low != 2) begin errors++; $display("FAIL urd_rdn_width got=%0d exp=2", t_rdn_low); end
    uart_dataready = 1'b0;
  endtask

  task automatic test_led_dpy();
    txn(1'b1, 32'hBFD0_0400, 4'hF, 1'b0, 32'h1234_ABCD, 1'b0);
    checks++; if (debug_leds !== 16'hABCD) begin errors++; $display("FAIL led_reg got=%h exp=abcd", debug_leds); end
    checks++; if (t_cycles != 1) begin errors++; $display("FAIL led_latency got=%0d exp=1", t_cycles); end
    txn(1'b0, 32'hBFD0_0400, 4'hF, 1'b0, 32'h0, 1'b0);
    checks++; if (t_rdata !== 32'h0000_ABCD) begin errors++; $display("FAIL led_read got=%h exp=0000abcd", t_rdata); end
    txn(1'b1, 32'hBFD0_0408, 4'hF, 1'b0, 32'hA5A5_A5C3, 1'b0);
    checks++; if (debug_dpys !== 8'hC3) begin errors++; $display("FAIL dpy_reg got=%h exp=c3", debug_dpys); end
  endtask

  task automatic test_back_to_back();
    txn(1'b0, 32'hBFD0_0400, 4'hF, 1'b0, 32'h0, 1'b1);
    checks++; if (t_rdata !== 32'h0000_ABCD) begin errors++; $display("FAIL b2b_first got=%h exp=0000abcd", t_rdata); end
    txn(1'b0, 32'hBFD0_0408, 4'hF, 1'b0, 32'h0, 1'b0);
    checks++; if (t_cycles != 2) begin errors++; $display("FAIL b2b_latency got=%0d exp=2", t_cycles); end
    checks++; if (t_rdata !== 32'h0000_00C3) begin errors++; $display("FAIL b2b_second got=%h exp=c3", t_rdata); end
  endtask

  task automatic test_reset_mid_write();
    int n = 0;
    bit ack_seen = 0;
    req = 1'b1; req_we = 1'b1; req_addr = 32'h8040_0020; req_be = 4'hF;
    req_unsigned = 1'b0; req_wdata = 32'hCAFE_F00D;
    while (sram_we_n[1] !== 1'b0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++; if (sram_we_n[1] !== 1'b0) begin errors++; $display("FAIL rmw_reach_wr got=%b exp=0", sram_we_n[1]); end
    rst = 1'b1;
    probe_en = 1'b1;
    #1;
    checks++;
    if ({sram_ce_n, sram_oe_n, sram_we_n, uart_rdn, uart_wrn} !== 8'hFF) begin
      errors++;
      $display("FAIL rmw_strobes got=%h exp=ff", {sram_ce_n, sram_oe_n, sram_we_n, uart_rdn, uart_wrn});
    end
    checks++; if (sram_data[63:32] !== 32'h1357_2468) begin errors++; $display("FAIL rmw_bus_release got=%h exp=13572468", sram_data[63:32]); end
    repeat (3) begin
      @(posedge clk); #1;
      if (ack) ack_seen = 1;
    end
    checks++; if (ack_seen) begin errors++; $display("FAIL rmw_no_ack got=1 exp=0"); end
    probe_en = 1'b0;
    req = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    txn(1'b0, 32'h8040_0010, 4'hF, 1'b0, 32'h0, 1'b0);
    checks++; if (t_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rmw_recover got=%h exp=deadbeef", t_rdata); end
    checks++; if (t_cycles != 2) begin errors++; $display("FAIL rmw_recover_latency got=%0d exp=2", t_cycles); end
  endtask

  initial begin
    test_reset();
    test_sram_word();
    test_lanes();
    test_uart_write();
    test_uart_read();
    test_led_dpy();
    test_back_to_back();
    test_reset_mid_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
